seed_overcurrent_interlock: RTL and testbench

Safety interlock directly downstream of the ADC control stage. It consumes each ADC current sample and its valid strobe, the mode-selected current trip limits, and the external seed comparator. It produces the latched `over_current_limit` that drives the over-current shutdown and laser-disable pins, plus a laser permit and trip diagnostics for the I2C status registers. Trips are fail-safe: once latched, a trip clears only through an explicit clear followed by a hold-off.

---
 rtl/seed_overcurrent_interlock.sv | 157 +++++++++++++++
 tb/tb_seed_overcurrent_interlock.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/seed_overcurrent_interlock.sv
// Over-current safety interlock: filters ADC samples, the seed comparator and the ADC
// watchdog into a latched, fail-safe trip that only clears via trip_clear plus a hold-off.
module seed_overcurrent_interlock #(
  parameter int unsigned TRIP_SAMPLES   = 3,
  parameter int unsigned CMP_FILTER     = 4,
  parameter int unsigned ADC_TIMEOUT    = 20000,
  parameter int unsigned HOLDOFF_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        dds_cw_mode_select,
  input  logic [15:0] dds_trip_limit,
  input  logic [15:0] cw_trip_limit,
  input  logic        adc_data_valid,
  input  logic [15:0] adc_current_data,
  input  logic        seed_compared,
  input  logic        trip_clear,
  output logic        over_current_limit,
  output logic        laser_permit,
  output logic [2:0]  trip_cause,
  output logic [7:0]  trip_count
);

  localparam int unsigned WdW = $clog2(ADC_TIMEOUT + 1);
  localparam int unsigned HoW = $clog2(HOLDOFF_CYCLES + 1);

  typedef enum logic [1:0] {StDisarmed, StArmed, StTripped, StHoldoff} state_e;

  state_e         state_q, state_d;
  logic           cmp_meta_q, cmp_sync_q;
  logic [7:0]     cmp_cnt_q, cmp_cnt_d;
  logic [3:0]     exc_cnt_q, exc_cnt_d;
  logic [WdW-1:0] wd_cnt_q, wd_cnt_d;
  logic [HoW-1:0] hold_cnt_q;
  logic           mode_q, enable_q, clear_q;
  logic           ocl_q, permit_q;
  logic [2:0]     cause_q;
  logic [7:0]     count_q;

  logic [15:0] limit;
  logic        over_limit, hit_a, hit_b, hit_c, trip, hold_done, trip_entry;

  always_comb begin
    limit      = dds_cw_mode_select ? cw_trip_limit : dds_trip_limit;
    over_limit = adc_current_data > limit;
    hit_a      = exc_cnt_q == 4'(TRIP_SAMPLES);
    // Filter must be saturated and the comparator still high, so a pulse of exactly
    // CMP_FILTER cycles is rejected.
    hit_b      = cmp_sync_q && (cmp_cnt_q == 8'(CMP_FILTER));
    hit_c      = wd_cnt_q == WdW'(ADC_TIMEOUT);
    trip       = (state_q == StArmed) && (hit_a || hit_b || hit_c);
    hold_done  = hold_cnt_q == HoW'(HOLDOFF_CYCLES - 1);

    cmp_cnt_d = cmp_cnt_q;
    if (!cmp_sync_q) begin
      cmp_cnt_d = '0;
    end else if (cmp_cnt_q != 8'(CMP_FILTER)) begin
      cmp_cnt_d = cmp_cnt_q + 8'd1;
    end

    exc_cnt_d = exc_cnt_q;
    if (state_q != StArmed || trip || dds_cw_mode_select != mode_q) begin
      exc_cnt_d = '0;
    end else if (adc_data_valid) begin
      if (!over_limit) begin
        exc_cnt_d = '0;
      end else if (!hit_a) begin
        exc_cnt_d = exc_cnt_q + 4'd1;
      end
    end

    wd_cnt_d = wd_cnt_q;
    if (state_q != StArmed || trip || adc_data_valid) begin
      wd_cnt_d = '0;
    end else if (!hit_c) begin
      wd_cnt_d = wd_cnt_q + WdW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_meta_q <= 1'b0;
      cmp_sync_q <= 1'b0;
      cmp_cnt_q  <= '0;
      exc_cnt_q  <= '0;
      wd_cnt_q   <= '0;
      mode_q     <= 1'b0;
      enable_q   <= 1'b0;
      clear_q    <= 1'b0;
    end else begin
      cmp_meta_q <= seed_compared;
      cmp_sync_q <= cmp_meta_q;
      cmp_cnt_q  <= cmp_cnt_d;
      exc_cnt_q  <= exc_cnt_d;
      wd_cnt_q   <= wd_cnt_d;
      mode_q     <= dds_cw_mode_select;
      enable_q   <= enable;
      clear_q    <= trip_clear;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (enable_q) state_d = StArmed;
      StArmed: begin
        if (trip) begin
          state_d = StTripped;
        end else if (!enable_q) begin
          state_d = StDisarmed;
        end
      end
      // A clear while the comparator is still high is dropped.
      StTripped: if (clear_q && !cmp_sync_q) state_d = StHoldoff;
      StHoldoff: begin
        if (hit_b) begin
          state_d = StTripped;
        end else if (hold_done) begin
          state_d = StDisarmed;
        end
      end
      default: state_d = StDisarmed;
    endcase
    trip_entry = (state_d == StTripped) && (state_q != StTripped);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StDisarmed;
      ocl_q      <= 1'b0;
      permit_q   <= 1'b0;
      cause_q    <= '0;
      count_q    <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      ocl_q      <= (state_d == StTripped) || (state_d == StHoldoff);
      permit_q   <= state_d == StArmed;
      hold_cnt_q <= (state_q == StHoldoff) ? hold_cnt_q + HoW'(1) : '0;
      if (trip_entry) begin
        cause_q <= (state_q == StArmed) ? {hit_c, hit_b, hit_a} : (cause_q | 3'b010);
        if (count_q != 8'hFF) begin
          count_q <= count_q + 8'd1;
        end
      end else if (state_q == StHoldoff && state_d == StDisarmed) begin
        cause_q <= '0;
      end
    end
  end

  assign over_current_limit = ocl_q;
  assign laser_permit       = permit_q;
  assign trip_cause         = cause_q;
  assign trip_count         = count_q;

endmodule

// File: tb/tb_seed_overcurrent_interlock.sv
// Bench for seed_overcurrent_interlock: directed scenarios plus random traffic, every cycle
// compared against a run-length based behavioural model of the interlock rules.
module tb_seed_overcurrent_interlock;

  localparam int TS = 3;
  localparam int CF = 4;
  localparam int TO = 20000;
  localparam int HO = 10000;

  localparam int M_DIS  = 0;
  localparam int M_ARM  = 1;
  localparam int M_TRIP = 2;
  localparam int M_HOLD = 3;

  logic        clk = 1'b0;
  logic        rstn, enable, mode, valid, clear, seed;
  logic [15:0] dds_lim, cw_lim, data;
  logic        ocl, permit;
  logic [2:0]  cause;
  logic [7:0]  count;

  int n_cmp = 0;
  int n_bad = 0;

  // Model: m_run1/m_run2 are the lengths of the current run of seed=1 samples as of the
  // last and the second-to-last edge.
  int m_st, m_cause, m_count, m_run1, m_run2, m_over, m_idle, m_hold;
  bit m_en, m_clr, m_mode;

  seed_overcurrent_interlock #(
    .TRIP_SAMPLES  (TS),
    .CMP_FILTER    (CF),
    .ADC_TIMEOUT   (TO),
    .HOLDOFF_CYCLES(HO)
  ) dut (
    .clk               (clk),
    .rstn              (rstn),
    .enable            (enable),
    .dds_cw_mode_select(mode),
    .dds_trip_limit    (dds_lim),
    .cw_trip_limit     (cw_lim),
    .adc_data_valid    (valid),
    .adc_current_data  (data),
    .seed_compared     (seed),
    .trip_clear        (clear),
    .over_current_limit(ocl),
    .laser_permit      (permit),
    .trip_cause        (cause),
    .trip_count        (count)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_DIS; m_cause = 0; m_count = 0; m_run1 = 0; m_run2 = 0;
    m_over = 0; m_idle = 0; m_hold = 0; m_en = 0; m_clr = 0; m_mode = 0;
  endtask

  task automatic model_step();
    bit bhit, cmp_low, armed, a, b, c, trip_now, over;
    int old_st;
    old_st   = m_st;
    bhit     = m_run2 >= CF + 1;
    cmp_low  = m_run2 == 0;
    armed    = m_st == M_ARM;
    a        = armed && (m_over >= TS);
    b        = armed && bhit;
    c        = armed && (m_idle >= TO);
    trip_now = a || b || c;
    case (m_st)
      M_DIS: if (m_en) m_st = M_ARM;
      M_ARM: begin
        if (trip_now) begin
          m_st    = M_TRIP;
          m_cause = int'({c, b, a});
          if (m_count < 255) m_count++;
        end else if (!m_en) begin
          m_st = M_DIS;
        end
      end
      M_TRIP: if (m_clr && cmp_low) begin m_st = M_HOLD; m_hold = 0; end
      M_HOLD: begin
        if (bhit) begin
          m_st    = M_TRIP;
          m_cause = m_cause | 2;
          if (m_count < 255) m_count++;
        end else begin
          m_hold++;
          if (m_hold == HO) begin m_st = M_DIS; m_cause = 0; end
        end
      end
      default: ;
    endcase
    over = data > (mode ? cw_lim : dds_lim);
    if (old_st != M_ARM || trip_now || mode != m_mode) m_over = 0;
    else if (valid) m_over = over ? m_over + 1 : 0;
    if (old_st != M_ARM || trip_now || valid) m_idle = 0;
    else m_idle++;
    m_run2 = m_run1;
    m_run1 = seed ? m_run1 + 1 : 0;
    m_en   = enable;
    m_clr  = clear;
    m_mode = mode;
  endtask

  task automatic check_model();
    check("ocl", 16'(ocl), 16'((m_st == M_TRIP || m_st == M_HOLD) ? 1 : 0));
    check("permit", 16'(permit), 16'((m_st == M_ARM) ? 1 : 0));
    check("cause", 16'(cause), 16'(m_cause));
    check("count", 16'(count), 16'(m_count));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) model_step();
    #1;
    check_model();
  endtask

  task automatic sample(input logic [15:0] d);
    valid = 1'b1;
    data  = d;
    tick();
    valid = 1'b0;
    data  = 16'($urandom);
  endtask

  // Asserts reset between edges and checks the outputs drop without waiting for a clock.
  task automatic do_reset();
    rstn = 1'b0;
    #1;
    model_reset();
    check("rst_ocl", 16'(ocl), 16'h0);
    check("rst_permit", 16'(permit), 16'h0);
    check("rst_cause", 16'(cause), 16'h0);
    check("rst_count", 16'(count), 16'h0);
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    int trip_age;
    rstn = 1'b1; enable = 0; mode = 0; valid = 0; clear = 0; seed = 0;
    dds_lim = 16'h4000; cw_lim = 16'h8000; data = 16'h0;
    #20;
    do_reset();

    // ADC over-limit trip, then clear through hold-off and re-arm.
    enable = 1'b1;
    tick(); tick();
    check("arm_permit", 16'(permit), 16'h1);
    sample(16'h4001); sample(16'h4001); sample(16'h4001);
    tick();
    check("adc_trip_ocl", 16'(ocl), 16'h1);
    check("adc_trip_cause", 16'(cause), 16'h1);
    check("adc_trip_count", 16'(count), 16'h1);
    clear = 1'b1; tick(); clear = 1'b0; tick();
    check("holdoff_ocl", 16'(ocl), 16'h1);
    repeat (HO - 1) tick();
    check("holdoff_end_ocl", 16'(ocl), 16'h1);
    tick();
    check("disarm_ocl", 16'(ocl), 16'h0);
    check("disarm_cause", 16'(cause), 16'h0);
    check("disarm_permit", 16'(permit), 16'h0);
    tick();
    check("rearm_permit", 16'(permit), 16'h1);

    // Interrupted over-limit run, at-limit samples, and an all-ones limit.
    sample(16'h4001); sample(16'h4001); sample(16'h4000); sample(16'h4001);
    tick(); tick();
    check("interrupted_ocl", 16'(ocl), 16'h0);
    repeat (4) sample(16'h4000);
    tick();
    check("at_limit_ocl", 16'(ocl), 16'h0);
    dds_lim = 16'hFFFF;
    repeat (4) sample(16'hFFFF);
    tick();
    check("max_limit_ocl", 16'(ocl), 16'h0);
    dds_lim = 16'h4000;

    // Comparator: 4-cycle glitch is rejected, 6-cycle pulse trips at edge 6.
    seed = 1'b1; repeat (4) tick(); seed = 1'b0;
    repeat (6) tick();
    check("glitch_ocl", 16'(ocl), 16'h0);
    seed = 1'b1; repeat (6) tick(); seed = 1'b0;
    check("cmp_edge5_ocl", 16'(ocl), 16'h0);
    tick();
    check("cmp_trip_ocl", 16'(ocl), 16'h1);
    check("cmp_trip_cause", 16'(cause), 16'h2);
    check("cmp_trip_count", 16'(count), 16'h2);

    // Clear while the comparator is high is dropped.
    seed = 1'b1; repeat (3) tick();
    clear = 1'b1; tick(); clear = 1'b0;
    repeat (3) tick();
    seed = 1'b0; repeat (4) tick();
    check("clear_dropped_ocl", 16'(ocl), 16'h1);

    // ADC watchdog timeout.
    do_reset();
    tick(); tick();
    check("wd_arm_permit", 16'(permit), 16'h1);
    repeat (TO) tick();
    check("wd_pre_ocl", 16'(ocl), 16'h0);
    tick();
    check("wd_trip_ocl", 16'(ocl), 16'h1);
    check("wd_trip_cause", 16'(cause), 16'h4);
    check("wd_trip_count", 16'(count), 16'h1);

    // ADC and comparator together while enable falls; then reset while tripped.
    do_reset();
    tick(); tick();
    seed = 1'b1;
    tick(); tick(); tick();
    sample(16'h4001); sample(16'h4001);
    enable = 1'b0;
    sample(16'h4001);
    tick();
    check("dual_trip_ocl", 16'(ocl), 16'h1);
    check("dual_trip_cause", 16'(cause), 16'h3);
    check("dual_trip_permit", 16'(permit), 16'h0);
    seed = 1'b0;
    do_reset();

    // Random traffic around the active limit; long trips are ended by reset.
    trip_age = 0;
    enable = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 199) == 0) dds_lim = 16'($urandom);
      if ($urandom_range(0, 199) == 0) cw_lim = ($urandom_range(0, 3) == 0) ? 16'hFFFF
                                                                           : 16'($urandom);
      if ($urandom_range(0, 63) == 0) mode = ~mode;
      if ($urandom_range(0, 15) == 0) seed = ~seed;
      enable = $urandom_range(0, 31) != 0;
      valid  = $urandom_range(0, 1) == 1;
      data   = 16'(int'(mode ? cw_lim : dds_lim) + int'($urandom_range(0, 2)) - 1);
      tick();
      trip_age = ocl ? trip_age + 1 : 0;
      if (trip_age > 8) begin
        valid = 1'b0;
        do_reset();
        trip_age = 0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
